// File: rtl/serial_alu_seq_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_alu_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_alu_seq_add1b.sv
// One-bit full adder: the single arithmetic cell reused every cycle.
module add1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);

  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer: streams two latched operands LSB-first
// through one full adder, then reports result, carry and signed overflow.
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] asa_q, asa_d;
  logic [WIDTH-1:0] bsb_q, bsb_d;
  logic [WIDTH-1:0] rsh_q, rsh_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    count_q, count_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             fa_r;
  logic             fa_co;

  add1b u_add1b (
    .a  (asa_q[0]),
    .b  (bsb_q[0]),
    .ci (cy_q),
    .r  (fa_r),
    .co (fa_co)
  );

  // Next-state and datapath updates; a new request is taken from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    asa_d   = asa_q;
    bsb_d   = bsb_q;
    rsh_d   = rsh_q;
    r_d     = r_q;
    count_d = count_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_RUN: begin
        rsh_d   = {fa_r, rsh_q[WIDTH-1:1]};
        cy_d    = fa_co;
        asa_d   = {1'b0, asa_q[WIDTH-1:1]};
        bsb_d   = {1'b0, bsb_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          // MSB step: cy_q is the carry into the sign bit
          r_d     = {fa_r, rsh_q[WIDTH-1:1]};
          co_d    = fa_co;
          ovf_d   = fa_co ^ cy_q;
          state_d = S_DONE;
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          // subtraction is a + ~b + 1: invert b and seed the carry with 1
          asa_d   = a;
          bsb_d   = (sub == OP_SUB) ? ~b : b;
          cy_d    = sub;
          count_d = '0;
          rsh_d   = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // State register; reset clears control and datapath alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      asa_q   <= '0;
      bsb_q   <= '0;
      rsh_q   <= '0;
      r_q     <= '0;
      count_q <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asa_q   <= asa_d;
      bsb_q   <= bsb_d;
      rsh_q   <= rsh_d;
      r_q     <= r_d;
      count_q <= count_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign r    = r_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8 and WIDTH=2.
module tb_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, co, ovf;
  logic [7:0] r;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, co2, ovf2;
  logic [1:0] r2;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .co(co), .ovf(ovf)
  );

  serial_alu_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .r(r2), .co(co2), .ovf(ovf2)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    start2 = 1'b0; sub2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, done, r, co, ovf} !== 11'b0) begin
      miss++;
      $display("FAIL reset_outputs: got busy=%b done=%b r=%h co=%b ovf=%b, want all 0",
               busy, done, r, co, ovf);
    end
    rst = 1'b0;
  endtask

  // Runs one operation from IDLE, checking busy for WIDTH cycles,
  // the done pulse and the registered results.
  task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] er, input logic eco,
                        input logic eovf);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = isub;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0; a = ~ia; b = ~ib;
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    end
    vec++;
    if (busy_cnt != 8) begin
      miss++;
      $display("FAIL %s_busy_cycles: got %0d, want 8", name, busy_cnt);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL %s_done_pulse: got done=%b busy=%b, want done=1 busy=0", name, done, busy);
    end
    vec++;
    if (r !== er || co !== eco || ovf !== eovf) begin
      miss++;
      $display("FAIL %s_result: got r=%h co=%b ovf=%b, want r=%h co=%b ovf=%b",
               name, r, co, ovf, er, eco, eovf);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL %s_done_width: got done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_add();
    run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int first_done, second_done;
    first_done = -1; second_done = -1;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h05; b = 8'h03;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done = k;
          vec++;
          if (r !== 8'h08 || co !== 1'b0 || ovf !== 1'b0) begin
            miss++;
            $display("FAIL b2b_first_result: got r=%h co=%b ovf=%b, want r=08 co=0 ovf=0",
                     r, co, ovf);
          end
          a = 8'h10; b = 8'h20;
        end else if (second_done < 0) begin
          second_done = k;
          start = 1'b0;
          vec++;
          if (r !== 8'h30 || co !== 1'b0 || ovf !== 1'b0) begin
            miss++;
            $display("FAIL b2b_second_result: got r=%h co=%b ovf=%b, want r=30 co=0 ovf=0",
                     r, co, ovf);
          end
        end
      end else begin
        a = 8'(k * 37); b = 8'(k * 91);
        if (first_done > 0 && k == first_done + 4) begin
          vec++;
          if (r !== 8'h08) begin
            miss++;
            $display("FAIL b2b_r_hold: got r=%h during second run, want 08", r);
          end
        end
      end
    end
    start = 1'b0;
    vec++;
    if (first_done != 9) begin
      miss++;
      $display("FAIL b2b_first_done_cycle: got %0d, want 9", first_done);
    end
    vec++;
    if (second_done - first_done != 9) begin
      miss++;
      $display("FAIL b2b_done_spacing: got %0d, want 9", second_done - first_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int stray_done;
    stray_done = 0;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h01;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({busy, done, r, co, ovf} !== 11'b0) begin
      miss++;
      $display("FAIL abort_outputs: got busy=%b done=%b r=%h co=%b ovf=%b, want all 0",
               busy, done, r, co, ovf);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray_done++;
    end
    vec++;
    if (stray_done != 0) begin
      miss++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", stray_done);
    end
    run_op("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
  endtask

  task automatic test_width2();
    int done_at;
    done_at = -1;
    @(negedge clk);
    start2 = 1'b1; sub2 = 1'b1; a2 = 2'b00; b2 = 2'b01;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2 === 1'b1 && done_at < 0) begin
        done_at = k;
        vec++;
        if (r2 !== 2'b11 || co2 !== 1'b0 || ovf2 !== 1'b0) begin
          miss++;
          $display("FAIL w2_sub_result: got r=%b co=%b ovf=%b, want r=11 co=0 ovf=0",
                   r2, co2, ovf2);
        end
      end
    end
    vec++;
    if (done_at != 3) begin
      miss++;
      $display("FAIL w2_done_cycle: got %0d, want 3", done_at);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_abort();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
